// File: rtl/vga_tile_timing.sv
// Raster timing generator with incremental tile/pixel/upscale decomposition.
// All outputs are registered from next-state values so they track the counters.
module vga_tile_timing #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int UPSCALE   = 5,
  parameter int TILE_SIZE = 8,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  output logic [9:0] counter_H,
  output logic [9:0] counter_V,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [3:0] tile_h,
  output logic [3:0] tile_v,
  output logic [2:0] pix_col,
  output logic [2:0] pix_row,
  output logic [2:0] up_h,
  output logic [2:0] up_v,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_MAX  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [2:0] UP_MAX = 3'(UPSCALE - 1);
  localparam logic [2:0] PX_MAX = 3'(TILE_SIZE - 1);
  localparam logic       S_ON   = SYNC_POL;
  localparam logic       S_OFF  = ~SYNC_POL;

  logic [9:0] counter_h_q, counter_h_d;
  logic [9:0] counter_v_q, counter_v_d;
  logic [3:0] tile_h_q, tile_h_d, tile_v_q, tile_v_d;
  logic [2:0] pix_col_q, pix_col_d, pix_row_q, pix_row_d;
  logic [2:0] up_h_q, up_h_d, up_v_q, up_v_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d;
  logic       display_on_q, display_on_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic       h_wrap, v_wrap;

  always_comb begin
    counter_h_d   = counter_h_q;
    counter_v_d   = counter_v_q;
    tile_h_d      = tile_h_q;
    tile_v_d      = tile_v_q;
    pix_col_d     = pix_col_q;
    pix_row_d     = pix_row_q;
    up_h_d        = up_h_q;
    up_v_d        = up_v_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    display_on_d  = display_on_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    h_wrap        = counter_h_q == H_MAX;
    v_wrap        = counter_v_q == V_MAX;

    if (pix_en) begin
      counter_h_d = h_wrap ? '0 : counter_h_q + 10'd1;
      if (h_wrap) begin
        counter_v_d = v_wrap ? '0 : counter_v_q + 10'd1;
      end

      // up -> pixel -> tile carry chain, parked at 0 outside the visible span
      if (counter_h_d == '0 || counter_h_d >= H_VIS) begin
        tile_h_d  = '0;
        pix_col_d = '0;
        up_h_d    = '0;
      end else if (up_h_q != UP_MAX) begin
        up_h_d = up_h_q + 3'd1;
      end else begin
        up_h_d = '0;
        if (pix_col_q != PX_MAX) begin
          pix_col_d = pix_col_q + 3'd1;
        end else begin
          pix_col_d = '0;
          tile_h_d  = tile_h_q + 4'd1;
        end
      end

      if (h_wrap) begin
        if (counter_v_d == '0 || counter_v_d >= V_VIS) begin
          tile_v_d  = '0;
          pix_row_d = '0;
          up_v_d    = '0;
        end else if (up_v_q != UP_MAX) begin
          up_v_d = up_v_q + 3'd1;
        end else begin
          up_v_d = '0;
          if (pix_row_q != PX_MAX) begin
            pix_row_d = pix_row_q + 3'd1;
          end else begin
            pix_row_d = '0;
            tile_v_d  = tile_v_q + 4'd1;
          end
        end
      end

      display_on_d  = (counter_h_d < H_VIS) && (counter_v_d < V_VIS);
      line_start_d  = counter_h_d == '0;
      frame_start_d = line_start_d && (counter_v_d == '0);
      hsync_d = (counter_h_d >= HS_BEG && counter_h_d <= HS_END) ? S_ON : S_OFF;
      vsync_d = (counter_v_d >= VS_BEG && counter_v_d <= VS_END) ? S_ON : S_OFF;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter_h_q   <= H_MAX;
      counter_v_q   <= V_MAX;
      tile_h_q      <= '0;
      tile_v_q      <= '0;
      pix_col_q     <= '0;
      pix_row_q     <= '0;
      up_h_q        <= '0;
      up_v_q        <= '0;
      hsync_q       <= S_OFF;
      vsync_q       <= S_OFF;
      display_on_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      counter_h_q   <= counter_h_d;
      counter_v_q   <= counter_v_d;
      tile_h_q      <= tile_h_d;
      tile_v_q      <= tile_v_d;
      pix_col_q     <= pix_col_d;
      pix_row_q     <= pix_row_d;
      up_h_q        <= up_h_d;
      up_v_q        <= up_v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      display_on_q  <= display_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign counter_H   = counter_h_q;
  assign counter_V   = counter_v_q;
  assign tile_h      = tile_h_q;
  assign tile_v      = tile_v_q;
  assign pix_col     = pix_col_q;
  assign pix_row     = pix_row_q;
  assign up_h        = up_h_q;
  assign up_v        = up_v_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign display_on  = display_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_tile_timing.sv
// Bench: default 640x480 instance plus a shrunken-raster instance for frame wrap.
// Both are compared every clock against an arithmetic raster model.
module tb_vga_tile_timing;

  typedef struct {
    int h, v, th, tv, pc, pr, uh, uv;
    int de, hs, vs, ls, fs;
  } out_t;

  typedef struct {
    int n, h, v, th, pc, uh, tv, pr, uv;
    int de, hs, ls, fs;
  } vec_t;

  // small instance: 96x87 raster, 80x80 visible, positive syncs
  localparam int BHV = 80, BHF = 4, BHS = 8, BHB = 4;
  localparam int BVV = 80, BVF = 2, BVS = 2, BVB = 3;
  localparam int BHT = BHV + BHF + BHS + BHB;
  localparam int BVT = BVV + BVF + BVS + BVB;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic pix_en = 1'b0;

  logic [9:0] a_ch, a_cv, b_ch, b_cv;
  logic       a_hs, a_vs, a_de, a_ls, a_fs;
  logic       b_hs, b_vs, b_de, b_ls, b_fs;
  logic [3:0] a_th, a_tv, b_th, b_tv;
  logic [2:0] a_pc, a_pr, a_uh, a_uv;
  logic [2:0] b_pc, b_pr, b_uh, b_uv;

  always #5 clk = ~clk;

  vga_tile_timing dut_a (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .counter_H(a_ch), .counter_V(a_cv),
    .hsync(a_hs), .vsync(a_vs), .display_on(a_de),
    .tile_h(a_th), .tile_v(a_tv),
    .pix_col(a_pc), .pix_row(a_pr),
    .up_h(a_uh), .up_v(a_uv),
    .line_start(a_ls), .frame_start(a_fs)
  );

  vga_tile_timing #(
    .H_VISIBLE(BHV), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
    .V_VISIBLE(BVV), .V_FRONT(BVF), .V_SYNC(BVS), .V_BACK(BVB),
    .SYNC_POL(1'b1)
  ) dut_b (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .counter_H(b_ch), .counter_V(b_cv),
    .hsync(b_hs), .vsync(b_vs), .display_on(b_de),
    .tile_h(b_th), .tile_v(b_tv),
    .pix_col(b_pc), .pix_row(b_pr),
    .up_h(b_uh), .up_v(b_uv),
    .line_start(b_ls), .frame_start(b_fs)
  );

  out_t a_o, b_o;
  always_comb begin
    a_o.h = int'(a_ch); a_o.v = int'(a_cv);
    a_o.th = int'(a_th); a_o.tv = int'(a_tv);
    a_o.pc = int'(a_pc); a_o.pr = int'(a_pr);
    a_o.uh = int'(a_uh); a_o.uv = int'(a_uv);
    a_o.de = int'(a_de); a_o.hs = int'(a_hs);
    a_o.vs = int'(a_vs); a_o.ls = int'(a_ls);
    a_o.fs = int'(a_fs);
  end
  always_comb begin
    b_o.h = int'(b_ch); b_o.v = int'(b_cv);
    b_o.th = int'(b_th); b_o.tv = int'(b_tv);
    b_o.pc = int'(b_pc); b_o.pr = int'(b_pr);
    b_o.uh = int'(b_uh); b_o.uv = int'(b_uv);
    b_o.de = int'(b_de); b_o.hs = int'(b_hs);
    b_o.vs = int'(b_vs); b_o.ls = int'(b_ls);
    b_o.fs = int'(b_fs);
  end

  int passed = 0;
  int total  = 0;
  int ah, av, bh, bv;
  int apulse, bpulse, bfs_last, hlow;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Expected outputs straight from the raster definition: divide/modulo.
  function automatic out_t model(input int h, input int v,
                                 input int hv, input int hsb, input int hse,
                                 input int vv, input int vsb, input int vse,
                                 input int pol);
    out_t e;
    int edge_px = 40;
    e.h = h;
    e.v = v;
    e.th = (h < hv) ? h / edge_px : 0;
    e.pc = (h < hv) ? (h % edge_px) / 5 : 0;
    e.uh = (h < hv) ? h % 5 : 0;
    e.tv = (v < vv) ? v / edge_px : 0;
    e.pr = (v < vv) ? (v % edge_px) / 5 : 0;
    e.uv = (v < vv) ? v % 5 : 0;
    e.de = (h < hv && v < vv) ? 1 : 0;
    e.hs = (h >= hsb && h <= hse) ? pol : 1 - pol;
    e.vs = (v >= vsb && v <= vse) ? pol : 1 - pol;
    e.ls = (h == 0) ? 1 : 0;
    e.fs = (h == 0 && v == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic cmp_out(input string t, input out_t a, input out_t e);
    chk({t, ".counter_H"}, a.h, e.h);
    chk({t, ".counter_V"}, a.v, e.v);
    chk({t, ".tile_h"}, a.th, e.th);
    chk({t, ".tile_v"}, a.tv, e.tv);
    chk({t, ".pix_col"}, a.pc, e.pc);
    chk({t, ".pix_row"}, a.pr, e.pr);
    chk({t, ".up_h"}, a.uh, e.uh);
    chk({t, ".up_v"}, a.uv, e.uv);
    chk({t, ".display_on"}, a.de, e.de);
    chk({t, ".hsync"}, a.hs, e.hs);
    chk({t, ".vsync"}, a.vs, e.vs);
    chk({t, ".line_start"}, a.ls, e.ls);
    chk({t, ".frame_start"}, a.fs, e.fs);
  endtask

  task automatic check_models();
    cmp_out("A", a_o, model(ah, av, 640, 656, 751, 480, 490, 491, 0));
    cmp_out("B", b_o, model(bh, bv, BHV, BHV + BHF, BHV + BHF + BHS - 1,
                            BVV, BVV + BVF, BVV + BVF + BVS - 1, 1));
  endtask

  task automatic model_reset();
    ah = 799; av = 524;
    bh = BHT - 1; bv = BVT - 1;
    apulse = 0; bpulse = 0; bfs_last = -1; hlow = 0;
  endtask

  task automatic tick(input bit en);
    pix_en = en;
    @(posedge clk);
    if (en) begin
      if (ah == 799) av = (av + 1) % 525;
      ah = (ah + 1) % 800;
      if (bh == BHT - 1) bv = (bv + 1) % BVT;
      bh = (bh + 1) % BHT;
      apulse++;
      bpulse++;
    end
    #1;
    check_models();
    if (en) begin
      if (a_hs == 1'b0) hlow++;
      else if (hlow != 0) begin
        chk("hsync_low_pixels", hlow, 96);
        hlow = 0;
      end
      if (b_fs) begin
        if (bfs_last >= 0) chk("frame_period_B", bpulse - bfs_last, BHT * BVT);
        bfs_last = bpulse;
      end
    end
  endtask

  vec_t vecs[13];
  int ls_clk;

  initial begin
    vecs[0]  = '{1,    0,   0, 0,  0, 0, 0, 0, 0, 1, 1, 1, 1};
    vecs[1]  = '{40,   39,  0, 0,  7, 4, 0, 0, 0, 1, 1, 0, 0};
    vecs[2]  = '{41,   40,  0, 1,  0, 0, 0, 0, 0, 1, 1, 0, 0};
    vecs[3]  = '{640,  639, 0, 15, 7, 4, 0, 0, 0, 1, 1, 0, 0};
    vecs[4]  = '{641,  640, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[5]  = '{656,  655, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[6]  = '{657,  656, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[7]  = '{752,  751, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[8]  = '{753,  752, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[9]  = '{800,  799, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[10] = '{801,  0,   1, 0,  0, 0, 0, 0, 1, 1, 1, 1, 0};
    vecs[11] = '{4801, 0,   6, 0,  0, 0, 0, 1, 1, 1, 1, 1, 0};
    vecs[12] = '{4840, 39,  6, 0,  7, 4, 0, 1, 1, 1, 1, 0, 0};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_models();
    @(negedge clk);
    reset = 1'b1;

    // released but idle: reset values must hold
    for (int i = 0; i < 10; i++) tick(1'b0);

    // directed raster points on the default instance
    for (int i = 0; i < 13; i++) begin
      for (int k = 0; k < 6000 && apulse < vecs[i].n; k++) tick(1'b1);
      chk($sformatf("vec%0d.pulses", i), apulse, vecs[i].n);
      chk($sformatf("vec%0d.h", i), int'(a_ch), vecs[i].h);
      chk($sformatf("vec%0d.v", i), int'(a_cv), vecs[i].v);
      chk($sformatf("vec%0d.tile_h", i), int'(a_th), vecs[i].th);
      chk($sformatf("vec%0d.pix_col", i), int'(a_pc), vecs[i].pc);
      chk($sformatf("vec%0d.up_h", i), int'(a_uh), vecs[i].uh);
      chk($sformatf("vec%0d.tile_v", i), int'(a_tv), vecs[i].tv);
      chk($sformatf("vec%0d.pix_row", i), int'(a_pr), vecs[i].pr);
      chk($sformatf("vec%0d.up_v", i), int'(a_uv), vecs[i].uv);
      chk($sformatf("vec%0d.display_on", i), int'(a_de), vecs[i].de);
      chk($sformatf("vec%0d.hsync", i), int'(a_hs), vecs[i].hs);
      chk($sformatf("vec%0d.line_start", i), int'(a_ls), vecs[i].ls);
      chk($sformatf("vec%0d.frame_start", i), int'(a_fs), vecs[i].fs);
    end

    // full rate through two complete frames of the small raster
    for (int k = 0; k < 20000 && bpulse < 2 * BHT * BVT + 20; k++)
      tick(1'b1);
    chk("B_frames_seen", (bfs_last == 2 * BHT * BVT + 1) ? 1 : 0, 1);

    // pix_en every second clock: line_start spans two clocks
    ls_clk = 0;
    for (int i = 0; i < 3400; i++) begin
      tick(i % 2 == 0);
      if (a_ls) ls_clk++;
      else if (ls_clk != 0) begin
        chk("line_start_clocks", ls_clk, 2);
        ls_clk = 0;
      end
    end

    // random pixel enable
    for (int i = 0; i < 8000; i++) tick(1'(($urandom & 3) != 0));

    // asynchronous reset between edges, mid-line
    for (int k = 0; k < 900 && ah != 300; k++) tick(1'b1);
    chk("reached_h300", ah, 300);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_models();
    #1;
    reset = 1'b1;
    tick(1'b0);
    tick(1'b1);
    chk("post_reset_frame_start", int'(a_fs), 1);
    for (int i = 0; i < 500; i++) tick(1'(($urandom & 1) != 0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vga_tile_timing.md
# vga_tile_timing

Raster timing generator for the 640x480@60 display path. It produces the `counter_H` and `counter_V` pixel counters consumed by the frame buffer controller, HSYNC/VSYNC, and a blanking flag. It also produces a pre-decomposed tile coordinate set: tile index, pixel-in-tile, and upscale phase. Downstream stages take these fields directly instead of re-deriving them from the pixel counters. It sits between the pixel-clock source and the frame buffer controller / VGA output pins.

## Interface
Parameters:
- `H_VISIBLE`, 640: visible pixels per line.
- `H_FRONT`, 16: horizontal front porch.
- `H_SYNC`, 96: HSYNC width.
- `H_BACK`, 48: horizontal back porch.
- `V_VISIBLE`, 480: visible lines.
- `V_FRONT`, 10: vertical front porch.
- `V_SYNC`, 2: VSYNC width.
- `V_BACK`, 33: vertical back porch.
- `UPSCALE`, 5: screen pixels per sprite pixel.
- `TILE_SIZE`, 8: sprite pixels per tile edge.
- `SYNC_POL`, 0: active level of hsync/vsync.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `pix_en`  in  1  pixel-rate enable; all state advances only on `clk` edges with `pix_en`=1.
- `counter_H`  out  10  pixel column, 0..H_TOTAL-1.
- `counter_V`  out  10  line, 0..V_TOTAL-1.
- `hsync`  out  1  horizontal sync.
- `vsync`  out  1  vertical sync.
- `display_on`  out  1  1 when `counter_H`<H_VISIBLE and `counter_V`<V_VISIBLE.
- `tile_h`  out  4  tile column, 0..15.
- `tile_v`  out  4  tile row, 0..11.
- `pix_col`  out  3  sprite pixel column within tile.
- `pix_row`  out  3  sprite pixel row within tile.
- `up_h`  out  3  horizontal upscale phase, 0..UPSCALE-1.
- `up_v`  out  3  vertical upscale phase, 0..UPSCALE-1.
- `line_start`  out  1  1 while `counter_H`==0.
- `frame_start`  out  1  1 while `counter_H`==0 and `counter_V`==0.

## Operation
Totals:
- H_TOTAL = sum of the H parameters (800 by default).
- V_TOTAL = sum of the V parameters (525 by default).
- Tile edge = TILE_SIZE*UPSCALE = 40 px, which gives a 16x12 tile grid exactly filling 640x480.

Counters:
- On each `pix_en` cycle, `counter_H` increments.
- At H_TOTAL-1 it wraps to 0 and `counter_V` increments.
- `counter_V` wraps to 0 at V_TOTAL-1 when `counter_H` wraps.

Tile decomposition is maintained incrementally as chained counters; no dividers or multipliers.
- Horizontal invariant while `counter_H`<H_VISIBLE: `counter_H` = `tile_h`*40 + `pix_col`*5 + `up_h`.
- Chain order: `up_h` counts 0..4, carry into `pix_col` 0..7, carry into `tile_h`.
- For `counter_H`>=H_VISIBLE, `tile_h`, `pix_col` and `up_h` are held at 0.
- Vertical fields obey the same invariant against `counter_V`. They advance only on the `pix_en` cycle where `counter_H` wraps, and are held at 0 for `counter_V`>=V_VISIBLE.

Sync and blanking:
- `hsync`=SYNC_POL for `counter_H` in [656,751], otherwise ~SYNC_POL.
- `vsync`=SYNC_POL for `counter_V` in [490,491], otherwise ~SYNC_POL.
- Defaults give 640x480@60 with negative syncs.

All outputs are registered and mutually consistent: every output always reflects the current `counter_H`/`counter_V`. Flags are therefore computed from next-state values.

## Timing
- Reset (asynchronous, `reset`=0) sets the state to the last pixel of a frame:
  - `counter_H`=799, `counter_V`=524;
  - all tile fields 0;
  - `display_on`=0, `line_start`=0, `frame_start`=0;
  - `hsync`=`vsync`=~SYNC_POL.
- The first `pix_en` after reset release yields (0,0) with `frame_start`=1, `line_start`=1 and `display_on`=1.
- Latency is zero between counter values and derived outputs: they change on the same `clk` edge.
- With `pix_en`=0, every output holds. Level outputs (`line_start`, `frame_start`) stay high for the whole pixel period, however many `clk` cycles that spans.
- Wrap-around: the `counter_H` 799->0 and `counter_V` 524->0 transitions occur on the same edge. All vertical fields return to 0 on that edge.
- Frame period is 420000 `pix_en` cycles.
- Reset asserted mid-line forces the reset state immediately, independent of `clk`. No partial frame is resumed.

## Test plan
- Reset, then `reset`=1 with `pix_en`=0 for 10 clocks -> outputs hold the reset values (799, 524, syncs inactive). Then one `pix_en` -> (0,0), `frame_start`=1, `display_on`=1.
- `pix_en` every clock, step from `counter_H`=39 to 40 -> `tile_h` 0->1, `pix_col` 7->0, `up_h` 4->0. Checker verifies the H/V invariant on every visible pixel of a full frame.
- Step from `counter_H`=639 to 640 -> `display_on` 1->0 and H tile fields 0. `hsync` goes low at exactly 656, returns high at 752, and runs 96 cycles.
- Run a full frame -> `vsync` low on lines 490-491 only. `tile_v`=11, `pix_row`=7, `up_v`=4 on line 479, all 0 on line 480. Next `frame_start` comes 420000 `pix_en` cycles after the first.
- `pix_en` asserted every 2nd clock (50 MHz clk) -> each pixel value lasts 2 clocks and `line_start` is high for 2 clocks. Results are identical to the ungated run when sampled per `pix_en`.
- Assert `reset` asynchronously at `counter_H`=300, `counter_V`=200 between clock edges -> outputs reach the reset values before the next edge. After release, the first `pix_en` gives (0,0).
